// File: rtl/reorder_buffer_pkg.sv
// Shared widths, types and helpers for the reorder buffer and the register-file
// rename/commit ports it drives.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int TAG_W     = 4;
   localparam int CNT_W     = TAG_W + 1;
   localparam int REG_W     = 5;
   localparam int XLEN      = 32;

   localparam logic [XLEN-1:0] NULL32 = '0;

   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]  word_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // Payload of one entry; busy/done live as separate bit vectors.
   typedef struct packed {
      logic     has_rd;
      reg_idx_t rd;
      word_t    val;
      logic     mispredict;
      word_t    target;
   } entry_t;

   typedef struct packed {
      logic     flag;
      reg_idx_t a;
      tag_t     rob;
   } rename_t;

   typedef struct packed {
      logic     flag;
      reg_idx_t a;
      word_t    val;
      tag_t     rob;
   } commit_t;

   // x0 is hardwired, so it is never renamed nor written back.
   function automatic logic writes_rd(input logic has_rd, input reg_idx_t rd);
      return has_rd && (rd != '0);
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, lookup, register-file and flush signals of the reorder buffer.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic     issue_valid;
   logic     issue_has_rd;
   reg_idx_t issue_rd;
   logic     issue_ok;
   tag_t     issue_tag;
   logic     full;

   logic     rd_in_flag;
   reg_idx_t rd_in_a;
   tag_t     rd_in_rob;

   tag_t     q1_tag;
   tag_t     q2_tag;
   logic     q1_ready;
   logic     q2_ready;
   word_t    q1_val;
   word_t    q2_val;

   logic     wb_valid;
   tag_t     wb_tag;
   word_t    wb_val;
   logic     wb_mispredict;
   word_t    wb_target;

   logic     rd_out_flag;
   reg_idx_t rd_out_a;
   word_t    rd_out_val;
   tag_t     rd_out_rob;

   logic     flush;
   word_t    flush_pc;

   modport master (
      output issue_valid, issue_has_rd, issue_rd,
      output q1_tag, q2_tag,
      output wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
      input  issue_ok, issue_tag, full,
      input  rd_in_flag, rd_in_a, rd_in_rob,
      input  q1_ready, q2_ready, q1_val, q2_val,
      input  rd_out_flag, rd_out_a, rd_out_val, rd_out_rob,
      input  flush, flush_pc
   );

   modport slave (
      input  issue_valid, issue_has_rd, issue_rd,
      input  q1_tag, q2_tag,
      input  wb_valid, wb_tag, wb_val, wb_mispredict, wb_target,
      output issue_ok, issue_tag, full,
      output rd_in_flag, rd_in_a, rd_in_rob,
      output q1_ready, q2_ready, q1_val, q2_val,
      output rd_out_flag, rd_out_a, rd_out_val, rd_out_rob,
      output flush, flush_pc
   );

endinterface

// File: rtl/reorder_buffer_rob_entry_array.sv
// Reorder buffer entry storage with the combinational operand lookup and
// CDB bypass used by dispatch.
module rob_entry_array
   import reorder_buffer_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     i_rdy,
   input  logic     i_issue_en,
   input  tag_t     i_issue_idx,
   input  logic     i_issue_has_rd,
   input  reg_idx_t i_issue_rd,
   input  logic     i_wb_valid,
   input  tag_t     i_wb_tag,
   input  word_t    i_wb_val,
   input  logic     i_wb_mispredict,
   input  word_t    i_wb_target,
   input  logic     i_commit_en,
   input  tag_t     i_head_idx,
   input  logic     i_flush,
   input  tag_t     i_q1_tag,
   input  tag_t     i_q2_tag,
   output logic     o_head_done,
   output entry_t   o_head,
   output logic     o_q1_ready,
   output word_t    o_q1_val,
   output logic     o_q2_ready,
   output word_t    o_q2_val
);

   logic [ROB_DEPTH-1:0] r_busy;
   logic [ROB_DEPTH-1:0] r_done;
   entry_t               r_entry [ROB_DEPTH];

   logic w_q1_byp;
   logic w_q2_byp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
         r_done <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) r_entry[i] <= '0;
      end else if (i_rdy) begin
         if (i_flush) begin
            r_busy <= '0;
            r_done <= '0;
         end else begin
            if (i_issue_en) begin
               r_busy[i_issue_idx]            <= 1'b1;
               r_done[i_issue_idx]            <= 1'b0;
               r_entry[i_issue_idx].has_rd     <= i_issue_has_rd;
               r_entry[i_issue_idx].rd         <= i_issue_rd;
               r_entry[i_issue_idx].mispredict <= 1'b0;
            end
            // Results for entries no longer in flight are stale and dropped.
            if (i_wb_valid && r_busy[i_wb_tag]) begin
               r_done[i_wb_tag]            <= 1'b1;
               r_entry[i_wb_tag].val        <= i_wb_val;
               r_entry[i_wb_tag].mispredict <= i_wb_mispredict;
               r_entry[i_wb_tag].target     <= i_wb_target;
            end
            if (i_commit_en) r_busy[i_head_idx] <= 1'b0;
         end
      end
   end

   assign o_head_done = r_done[i_head_idx];
   assign o_head      = r_entry[i_head_idx];

   assign w_q1_byp   = i_wb_valid && (i_wb_tag == i_q1_tag);
   assign w_q2_byp   = i_wb_valid && (i_wb_tag == i_q2_tag);
   assign o_q1_ready = r_done[i_q1_tag] || w_q1_byp;
   assign o_q2_ready = r_done[i_q2_tag] || w_q2_byp;
   assign o_q1_val   = w_q1_byp ? i_wb_val : r_entry[i_q1_tag].val;
   assign o_q2_val   = w_q2_byp ? i_wb_val : r_entry[i_q2_tag].val;

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: renames at issue, retires the head in order,
// and raises a one-cycle flush when a mispredicted branch commits.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   reorder_buffer_if.slave bus
);

   tag_t     r_head;
   tag_t     r_tail;
   cnt_t     r_count;
   logic     r_rd_out_flag;
   reg_idx_t r_rd_out_a;
   word_t    r_rd_out_val;
   tag_t     r_rd_out_rob;
   logic     r_flush;
   word_t    r_flush_pc;

   logic   w_head_done;
   entry_t w_head;
   logic   w_full;
   logic   w_commit;
   logic   w_commit_flush;
   logic   w_issue_ok;

   // Commit looks only at the registered done bit, so a result always spends
   // at least one cycle in the buffer before it retires.
   assign w_full         = (r_count == cnt_t'(ROB_DEPTH));
   assign w_commit       = rdy && (r_count != '0) && w_head_done;
   assign w_commit_flush = w_commit && w_head.mispredict;
   assign w_issue_ok     = bus.issue_valid && rdy && !w_full && !w_commit_flush;

   assign bus.issue_ok   = w_issue_ok;
   assign bus.issue_tag  = r_tail;
   assign bus.full       = w_full;
   assign bus.rd_in_flag = w_issue_ok && writes_rd(bus.issue_has_rd, bus.issue_rd);
   assign bus.rd_in_a    = bus.issue_rd;
   assign bus.rd_in_rob  = r_tail;

   assign bus.rd_out_flag = r_rd_out_flag;
   assign bus.rd_out_a    = r_rd_out_a;
   assign bus.rd_out_val  = r_rd_out_val;
   assign bus.rd_out_rob  = r_rd_out_rob;
   assign bus.flush       = r_flush;
   assign bus.flush_pc    = r_flush_pc;

   rob_entry_array u_entries (
      .clk             (clk),
      .rst             (rst),
      .i_rdy           (rdy),
      .i_issue_en      (w_issue_ok),
      .i_issue_idx     (r_tail),
      .i_issue_has_rd  (bus.issue_has_rd),
      .i_issue_rd      (bus.issue_rd),
      .i_wb_valid      (bus.wb_valid),
      .i_wb_tag        (bus.wb_tag),
      .i_wb_val        (bus.wb_val),
      .i_wb_mispredict (bus.wb_mispredict),
      .i_wb_target     (bus.wb_target),
      .i_commit_en     (w_commit),
      .i_head_idx      (r_head),
      .i_flush         (w_commit_flush),
      .i_q1_tag        (bus.q1_tag),
      .i_q2_tag        (bus.q2_tag),
      .o_head_done     (w_head_done),
      .o_head          (w_head),
      .o_q1_ready      (bus.q1_ready),
      .o_q1_val        (bus.q1_val),
      .o_q2_ready      (bus.q2_ready),
      .o_q2_val        (bus.q2_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_rd_out_flag <= 1'b0;
         r_rd_out_a    <= '0;
         r_rd_out_val  <= NULL32;
         r_rd_out_rob  <= '0;
         r_flush       <= 1'b0;
         r_flush_pc    <= NULL32;
      end else begin
         // Pulses update every cycle so they drop even while frozen.
         r_rd_out_flag <= w_commit && writes_rd(w_head.has_rd, w_head.rd);
         r_flush       <= w_commit_flush;
         r_flush_pc    <= w_commit_flush ? w_head.target : NULL32;
         if (w_commit) begin
            r_rd_out_a   <= w_head.rd;
            r_rd_out_val <= w_head.val;
            r_rd_out_rob <= r_head;
         end
         if (rdy) begin
            if (w_commit_flush) begin
               r_head  <= '0;
               r_tail  <= '0;
               r_count <= '0;
            end else begin
               if (w_commit)   r_head <= r_head + tag_t'(1);
               if (w_issue_ok) r_tail <= r_tail + tag_t'(1);
               unique case ({w_issue_ok, w_commit})
                  2'b10:   r_count <= r_count + cnt_t'(1);
                  2'b01:   r_count <= r_count - cnt_t'(1);
                  default: r_count <= r_count;
               endcase
            end
         end
      end
   end

endmodule
